// File: rtl/vga_pkg.sv
// Shared VGA timing constants for the 640x480@60 Hz display path.
// The board renderer imports H_VIS/V_VIS from here so both sides agree on the visible area.
package vga_pkg;

    localparam int unsigned RGB_W   = 10;
    localparam int unsigned COORD_W = 10;

    localparam int unsigned H_VIS  = 640;
    localparam int unsigned H_FP   = 16;
    localparam int unsigned H_SYNC = 96;
    localparam int unsigned H_BP   = 48;
    localparam int unsigned H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned H_SYNC_START = H_VIS + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam int unsigned V_VIS  = 480;
    localparam int unsigned V_FP   = 10;
    localparam int unsigned V_SYNC = 2;
    localparam int unsigned V_BP   = 33;
    localparam int unsigned V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned V_SYNC_START = V_VIS + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

endpackage

// File: rtl/vga_pixel_tick.sv
// Pixel-rate divider: one pix_tick per PIX_DIV system clocks, plus the DAC pixel clock.
module vga_pixel_tick
    import vga_pkg::*;
#(
    parameter int unsigned PIX_DIV = 2
) (
    input  logic clk,
    input  logic resetn,
    output logic pix_tick,
    output logic vga_clk
);

    localparam int unsigned CntW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(PIX_DIV - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(PIX_DIV / 2);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        pix_tick = (cnt_q == CntLast);
        cnt_d    = pix_tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    if (PIX_DIV == 1) begin : g_clk_inv
        logic en_q;
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) en_q <= 1'b0;
            else         en_q <= 1'b1;
        end
        // DAC latches on the rising edge of ~clk, i.e. mid-way through each pixel.
        assign vga_clk = ~clk & en_q;
    end else begin : g_clk_div
        // Rises half a pixel after the stage-1 update so the DAC samples stable data.
        assign vga_clk = (cnt_q >= CntHalf);
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// Raster counters plus a one-pixel registered output stage keeping sync, blank and colour aligned.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned PIX_DIV = 2,
    parameter int unsigned H_VIS   = vga_pkg::H_VIS,
    parameter int unsigned H_FP    = vga_pkg::H_FP,
    parameter int unsigned H_SYNC  = vga_pkg::H_SYNC,
    parameter int unsigned H_BP    = vga_pkg::H_BP,
    parameter int unsigned V_VIS   = vga_pkg::V_VIS,
    parameter int unsigned V_FP    = vga_pkg::V_FP,
    parameter int unsigned V_SYNC  = vga_pkg::V_SYNC,
    parameter int unsigned V_BP    = vga_pkg::V_BP
) (
    input  logic               clk,
    input  logic               resetn,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    input  logic [RGB_W-1:0]   red,
    input  logic [RGB_W-1:0]   green,
    input  logic [RGB_W-1:0]   blue,
    output logic [RGB_W-1:0]   vga_r,
    output logic [RGB_W-1:0]   vga_g,
    output logic [RGB_W-1:0]   vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_blank_n,
    output logic               vga_sync_n,
    output logic               vga_clk,
    output logic               frame_start
);

    localparam int unsigned HTotal = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTotal = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [COORD_W-1:0] HLast   = COORD_W'(HTotal - 1);
    localparam logic [COORD_W-1:0] VLast   = COORD_W'(VTotal - 1);
    localparam logic [COORD_W-1:0] HVis    = COORD_W'(H_VIS);
    localparam logic [COORD_W-1:0] VVis    = COORD_W'(V_VIS);
    localparam logic [COORD_W-1:0] HSyncSt = COORD_W'(H_VIS + H_FP);
    localparam logic [COORD_W-1:0] HSyncEn = COORD_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VSyncSt = COORD_W'(V_VIS + V_FP);
    localparam logic [COORD_W-1:0] VSyncEn = COORD_W'(V_VIS + V_FP + V_SYNC);

    logic pix_tick;

    vga_pixel_tick #(
        .PIX_DIV (PIX_DIV)
    ) u_pixel_tick (
        .clk      (clk),
        .resetn   (resetn),
        .pix_tick (pix_tick),
        .vga_clk  (vga_clk)
    );

    logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
    logic [RGB_W-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
    logic               hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
    logic               h_last, v_last, vis;

    always_comb begin
        h_last = (h_q == HLast);
        v_last = (v_q == VLast);
        vis    = (h_q < HVis) && (v_q < VVis);

        h_d       = h_q;
        v_d       = v_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        blank_n_d = blank_n_q;

        if (pix_tick) begin
            h_d = h_last ? '0 : h_q + 1'b1;
            if (h_last) v_d = v_last ? '0 : v_q + 1'b1;

            // Stage 1 decodes the coordinate currently on x/y, landing one pixel later.
            r_d       = vis ? red   : '0;
            g_d       = vis ? green : '0;
            b_d       = vis ? blue  : '0;
            hs_d      = !((h_q >= HSyncSt) && (h_q < HSyncEn));
            vs_d      = !((v_q >= VSyncSt) && (v_q < VSyncEn));
            blank_n_d = vis;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_q       <= '0;
            v_q       <= '0;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            blank_n_q <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            blank_n_q <= blank_n_d;
        end
    end

    assign x           = h_q;
    assign y           = v_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign vga_sync_n  = 1'b0;
    assign frame_start = pix_tick & h_last & v_last;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench: a shrunk-raster PIX_DIV=2 instance and a full-raster PIX_DIV=1 instance.
module tb_vga_timing_ctrl;

    // Shrunk raster for instance A: 32 pixels x 15 lines, 480 pixels per frame.
    localparam int unsigned AHVis = 16, AHFp = 4, AHSync = 6, AHBp = 6;
    localparam int unsigned AVVis = 8,  AVFp = 2, AVSync = 2, AVBp = 3;
    localparam int unsigned AHTot = 32, AVTot = 15;
    localparam int unsigned AHSyncSt = 20;
    localparam int unsigned AFrameClk = 2 * AHTot * AVTot;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [9:0] x_a, y_a, r_a, g_a, b_a, x_b, y_b, r_b, g_b, b_b;
    logic hs_a, vs_a, bl_a, sn_a, vc_a, fs_a, hs_b, vs_b, bl_b, sn_b, vc_b, fs_b;

    vga_timing_ctrl #(
        .PIX_DIV (2),
        .H_VIS (AHVis), .H_FP (AHFp), .H_SYNC (AHSync), .H_BP (AHBp),
        .V_VIS (AVVis), .V_FP (AVFp), .V_SYNC (AVSync), .V_BP (AVBp)
    ) u_dut_a (
        .clk (clk), .resetn (resetn), .x (x_a), .y (y_a),
        .red (x_a), .green (y_a), .blue (10'h3ff),
        .vga_r (r_a), .vga_g (g_a), .vga_b (b_a), .vga_hs (hs_a), .vga_vs (vs_a),
        .vga_blank_n (bl_a), .vga_sync_n (sn_a), .vga_clk (vc_a), .frame_start (fs_a)
    );

    vga_timing_ctrl #(
        .PIX_DIV (1)
    ) u_dut_b (
        .clk (clk), .resetn (resetn), .x (x_b), .y (y_b),
        .red (x_b), .green (y_b), .blue (10'h3ff),
        .vga_r (r_b), .vga_g (g_b), .vga_b (b_b), .vga_hs (hs_b), .vga_vs (vs_b),
        .vga_blank_n (bl_b), .vga_sync_n (sn_b), .vga_clk (vc_b), .frame_start (fs_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_x"},  32'(x_a),  0);
        check({tag, "_y"},  32'(y_a),  0);
        check({tag, "_rgb"}, 32'({r_a, g_a, b_a} != 0), 0);
        check({tag, "_hs"}, 32'(hs_a), 1);
        check({tag, "_vs"}, 32'(vs_a), 1);
        check({tag, "_bl"}, 32'(bl_a), 0);
        check({tag, "_fs"}, 32'(fs_a), 0);
        check({tag, "_vclk"}, 32'(vc_a), 0);
        check({tag, "_xb"}, 32'(x_b),  0);
        check({tag, "_vclkb"}, 32'(vc_b), 0);
    endtask

    initial begin
        int n;
        int x_at_fall;
        logic [9:0] ysave;

        // Reset held for 10 clocks
        repeat (10) @(negedge clk);
        check_reset_vals("rst");
        check("sync_n", 32'(sn_a), 0);
        resetn = 1'b1;

        tick();
        check("first_edge_xa", 32'(x_a), 0);
        check("first_edge_xb", 32'(x_b), 1);
        tick();
        check("second_edge_xa", 32'(x_a), 1);
        check("second_edge_xb", 32'(x_b), 2);
        check("vclk_b_low_after_pos", 32'(vc_b), 0);
        @(negedge clk);
        #1;
        check("vclk_b_high_at_neg", 32'(vc_b), 1);

        // PIX_DIV=1: colour one clock after its coordinate
        n = 0;
        do begin tick(); n++; end while (x_b != 10'd5 && n < 100);
        ysave = y_b;
        tick();
        check("b_r", 32'(r_b), 5);
        check("b_g", 32'(g_b), 32'(ysave));
        check("b_b", 32'(b_b), 32'h3ff);
        check("b_blank", 32'(bl_b), 1);

        // PIX_DIV=1 line period
        n = 0;
        while (hs_b !== 1'b0 && n < 2000) begin tick(); n++; end
        check("b_hs_seen", 32'(hs_b), 0);
        n = 0;
        while (hs_b === 1'b0 && n < 2000) begin tick(); n++; end
        while (hs_b === 1'b1 && n < 2000) begin tick(); n++; end
        check("b_line_period", 32'(n), 800);

        // Instance A: hsync width, falling-edge position and line period
        n = 0;
        while (hs_a !== 1'b1 && n < 200) begin tick(); n++; end
        while (hs_a === 1'b1 && n < 200) begin tick(); n++; end
        x_at_fall = 32'(x_a);
        check("a_hs_fall_x", 32'(x_at_fall), AHSyncSt + 1);
        n = 0;
        while (hs_a === 1'b0 && n < 200) begin tick(); n++; end
        check("a_hs_width", 32'(n), 2 * AHSync);
        while (hs_a === 1'b1 && n < 200) begin tick(); n++; end
        check("a_line_period", 32'(n), 2 * AHTot);

        // Last visible pixel
        n = 0;
        while (!(x_a == 10'(AHVis - 1) && y_a == 10'(AVVis - 1)) && n < 2000) begin
            tick(); n++;
        end
        repeat (2) tick();
        check("a_last_vis_r", 32'(r_a), AHVis - 1);
        check("a_last_vis_g", 32'(g_a), AVVis - 1);
        check("a_last_vis_b", 32'(b_a), 32'h3ff);
        check("a_last_vis_bl", 32'(bl_a), 1);

        // vsync width
        n = 0;
        while (vs_a === 1'b1 && n < 2000) begin tick(); n++; end
        n = 0;
        while (vs_a === 1'b0 && n < 2000) begin tick(); n++; end
        check("a_vs_width", 32'(n), 2 * AVSync * AHTot);

        // First pixel past the visible width on line 0
        n = 0;
        while (!(x_a == 10'(AHVis) && y_a == 10'd0) && n < 2000) begin tick(); n++; end
        repeat (2) tick();
        check("a_hblank_rgb", 32'({r_a, g_a, b_a} != 0), 0);
        check("a_hblank_bl", 32'(bl_a), 0);

        // frame_start width and period
        n = 0;
        while (fs_a !== 1'b1 && n < 2000) begin tick(); n++; end
        check("a_fs_seen", 32'(fs_a), 1);
        check("a_fs_x", 32'(x_a), AHTot - 1);
        check("a_fs_y", 32'(y_a), AVTot - 1);
        tick();
        check("a_fs_width", 32'(fs_a), 0);
        check("a_wrap_x", 32'(x_a), 0);
        n = 1;
        while (fs_a !== 1'b1 && n < 3000) begin tick(); n++; end
        check("a_frame_period", 32'(n), AFrameClk);

        // Mid-frame reset at (10,5)
        n = 0;
        while (!(x_a == 10'd10 && y_a == 10'd5) && n < 2000) begin tick(); n++; end
        resetn = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        n = 0;
        while (fs_a !== 1'b1 && n < 3000) begin tick(); n++; end
        check("a_fs_after_rst", 32'(n), AFrameClk - 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
